// File: rtl/image_pingpong_buf.sv
// Double-buffered image store: the loader fills one bank while the inference
// engine reads the completed image from the other through an asynchronous port.
module image_pingpong_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              wr_restart,
  output logic              frame_written,
  output logic              overflow,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              img_valid,
  input  logic              rd_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              frame_written_q, frame_written_d;

  logic accept;
  logic release_img;

  assign wr_ready      = ~full_q[wr_bank_q];
  assign img_valid     = full_q[rd_bank_q];
  assign overflow      = overflow_q;
  assign frame_written = frame_written_q;

  assign accept      = wr_valid & wr_ready & ~wr_restart;
  assign release_img = rd_done & img_valid;

  // Restart wins over a same-cycle write; completion and release never hit the same bank.
  always_comb begin
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    wr_ptr_d        = wr_ptr_q;
    full_d          = full_q;
    overflow_d      = overflow_q;
    frame_written_d = 1'b0;

    if (wr_restart) begin
      wr_ptr_d = '0;
    end else if (accept) begin
      if (wr_ptr_q == LAST_ADDR) begin
        wr_ptr_d           = '0;
        full_d[wr_bank_q]  = 1'b1;
        wr_bank_d          = ~wr_bank_q;
        frame_written_d    = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (release_img) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (wr_valid && !wr_ready && !wr_restart) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      wr_ptr_q        <= '0;
      full_q          <= 2'b00;
      overflow_q      <= 1'b0;
      frame_written_q <= 1'b0;
    end else begin
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      wr_ptr_q        <= wr_ptr_d;
      full_q          <= full_d;
      overflow_q      <= overflow_d;
      frame_written_q <= frame_written_d;
    end
  end

  // Pixel storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_bank_q][wr_ptr_q[IDX_W-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr <= LAST_ADDR) begin
      rd_data = mem_q[rd_bank_q][rd_addr[IDX_W-1:0]];
    end
  end

endmodule

// File: tb/tb_image_pingpong_buf.sv
// Self-checking bench for image_pingpong_buf: directed scenarios plus random
// traffic compared against a queue-of-images reference model.
module tb_image_pingpong_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              wr_restart = 1'b0;
  logic              frame_written;
  logic              overflow;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              img_valid;
  logic              rd_done = 1'b0;

  image_pingpong_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_restart(wr_restart), .frame_written(frame_written),
    .overflow(overflow), .rd_addr(rd_addr), .rd_data(rd_data),
    .img_valid(img_valid), .rd_done(rd_done)
  );

  always #10 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: completed images waiting for the reader, plus the image in progress.
  logic [DATA_W*DEPTH-1:0] done_img[$];
  int                      part[$];
  bit                      ovf_m = 1'b0;
  bit                      fw_m = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [DATA_W*DEPTH-1:0] img;
    logic [DATA_W-1:0]       exp_px;
    checkOutput("wr_ready", 32'(wr_ready), 32'(done_img.size() < 2));
    checkOutput("img_valid", 32'(img_valid), 32'(done_img.size() > 0));
    checkOutput("frame_written", 32'(frame_written), 32'(fw_m));
    checkOutput("overflow", 32'(overflow), 32'(ovf_m));
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      rd_addr = ADDR_W'(a);
      #1;
      if (a >= DEPTH) begin
        checkOutput("rd_data_oob", 32'(rd_data), 32'd0);
      end else if (done_img.size() > 0) begin
        img    = done_img[0];
        exp_px = img[DATA_W*a +: DATA_W];
        checkOutput("rd_data", 32'(rd_data), 32'(exp_px));
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit dn);
    bit ready;
    bit rel;
    logic [DATA_W*DEPTH-1:0] img;
    ready = (done_img.size() < 2);
    rel   = dn && (done_img.size() > 0);
    wr_valid   = v;
    wr_data    = d;
    wr_restart = r;
    rd_done    = dn;
    @(posedge clk);
    #1;
    wr_valid   = 1'b0;
    wr_restart = 1'b0;
    rd_done    = 1'b0;
    fw_m = 1'b0;
    if (rel) void'(done_img.pop_front());
    if (r) begin
      part.delete();
    end else if (v) begin
      if (ready) begin
        part.push_back(int'(d));
        if (part.size() == DEPTH) begin
          img = '0;
          for (int i = 0; i < DEPTH; i++) img[DATA_W*i +: DATA_W] = DATA_W'(part[i]);
          done_img.push_back(img);
          part.delete();
          fw_m = 1'b1;
        end
      end else begin
        ovf_m = 1'b1;
      end
    end
    checkAll();
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_restart = 1'b0;
    rd_done    = 1'b0;
    done_img.delete();
    part.delete();
    ovf_m = 1'b0;
    fw_m  = 1'b0;
    #1;
    checkAll();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic writeImage(input int base);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DATA_W'(base + i), 1'b0, 1'b0);
  endtask

  initial begin
    #3;
    doReset();

    // Single image streamed back to back
    writeImage(10);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Two images without release, then overflow
    doReset();
    writeImage(20);
    writeImage(30);
    applyStimulus(1'b1, 8'd99, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Release twice
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Restart with a pixel presented in the same cycle
    doReset();
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd77, 1'b1, 1'b0);
    writeImage(7);

    // Completion of bank 1 coinciding with release of bank 0
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd41, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd43, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Reset in the middle of an image
    applyStimulus(1'b1, 8'd60, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd61, 1'b0, 1'b0);
    doReset();
    writeImage(50);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 9) < 7, DATA_W'($urandom),
                      $urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
